serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial N-bit adder: one 1-bit full-adder cell (a^b^cin / majority carry) reused
//   over WIDTH cycles, with a carry flip-flop. Captures operands, shifts one bit per
//   clock LSB-first, returns an N-bit sum plus carry-out with a start/busy/done handshake.
//   Area-minimal alternative to a ripple adder; driven by a higher-level sequencer/bench.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2); bit counter is $clog2(WIDTH+1) wide
// PORTS
//   clk     in   1      single clock, all state on rising edge
//   rst_n   in   1      synchronous reset, active-low
//   start   in   1      request; accepted only in IDLE
//   a       in   WIDTH  operand A, sampled on accepted start
//   b       in   WIDTH  operand B, sampled on accepted start
//   cin     in   1      carry-in, sampled on accepted start
//   busy    out  1      1 while in RUN
//   done    out  1      1-cycle pulse: result registers just updated
//   sum     out  WIDTH  result, held until next completion
//   cout    out  1      carry-out of MSB, held with sum
//   ovf     out  1      signed overflow (only with SERIAL_ADD_OVF_EN)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0,
//     operand shift regs, carry FF and counter cleared. Overrides all else.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     IDLE: start=1 at edge E0 -> load a_sh=a, b_sh=b, carry=cin, cnt=0; go RUN.
//     RUN: each edge: bit=a_sh[0]^b_sh[0]^carry; carry<=maj(a_sh[0],b_sh[0],carry);
//       shift a_sh,b_sh right; shift bit into MSB of internal res_sh; cnt++.
//       At edge where cnt reaches WIDTH (edge E0+WIDTH): sum<=final res_sh, cout<=final
//       carry, done<=1; go DONE.
//     DONE: done=1 for exactly this one cycle; next edge -> IDLE, done<=0.
//   - Latency: done high in the cycle after edge E0+WIDTH; next start accepted in IDLE
//     at earliest edge E0+WIDTH+2 (throughput: one op per WIDTH+2 cycles).
//   - busy=1 exactly WIDTH cycles (RUN); busy and done never both 1.
//   - start in RUN or DONE ignored (not queued); a/b/cin changes after E0 have no effect.
//   - start held high continuously: new op accepted on every IDLE edge.
//   - sum/cout only change on completion edge or reset; never show partial results.
//   - Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1), unsigned.
//   - Reset mid-RUN: operation abandoned, no done pulse, outputs to reset values.
// CONFIGURATION
//   SERIAL_ADD_OVF_EN defined: port ovf present; at completion ovf<=carry into MSB XOR
//     carry out of MSB (two's-complement overflow); held with sum; 0 on reset.
//   SERIAL_ADD_OVF_EN undefined: no ovf port, no extra FF; all else identical.
// TESTING (WIDTH=8)
//   1. a=00 b=00 cin=0 start 1 cycle -> busy 8 cycles, done 1 cycle, sum=00 cout=0.
//   2. a=FF b=01 cin=0 -> sum=00 cout=1 (full-length carry propagation).
//   3. a=A5 b=5A cin=1 -> sum=00 cout=1; then a=3C b=0F cin=0 -> sum=4B cout=0, old
//      result held through second RUN.
//   4. start a=12 b=34 then pulse start with a=FF b=FF at RUN cycle 3 -> single done,
//      sum=46 cout=0.
//   5. a=FF b=FF cin=1, rst_n=0 at RUN cycle 4 -> busy=0 done=0 sum=00 cout=0, no done
//      after; next op a=01 b=01 -> sum=02.
//   6. OVF_EN: a=7F b=01 -> sum=80 ovf=1 cout=0; a=80 b=80 -> sum=00 ovf=1 cout=1;
//      a=40 b=20 -> sum=60 ovf=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake/operand bus between a sequencer (master) and the bit-serial adder (slave).
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output (bus.ovf).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             sum_bit;
    logic             carry_nx;
    logic             last_step;

    // NOTE: always_comb assigns every output on every path, so no latches are inferred.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf  <= 1'b0;
`endif
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nx;
                    // Result bits enter at the top; after WIDTH-1 steps the
                    // register holds the low bits of the sum, LSB at index 0.
                    res_sh <= {sum_bit, res_sh} >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        bus.sum  <= {sum_bit, res_sh};
                        bus.cout <= carry_nx;
`ifdef SERIAL_ADD_OVF_EN
                        // carry is the carry into the MSB at this step
                        bus.ovf  <= carry ^ carry_nx;
`endif
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, randomized ops
// against an arithmetic model, and hand-written handshake/reset corner sequences.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [W-1:0] held_sum;
    logic         held_cout;

    serial_adder_if #(.WIDTH(W)) ifc ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation and checks the result against plain arithmetic.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input string name);
        logic [W:0] full;
        int         busy_n;
        bit         got;
        full = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.a     = a;
        ifc.b     = b;
        ifc.cin   = cin;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.a     = W'($urandom);
        ifc.b     = W'($urandom);
        ifc.cin   = 1'($urandom);
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ifc.busy === 1'b1) busy_n++;
            if (i == 3) begin
                check({name, " held sum"}, 32'(ifc.sum), 32'(held_sum));
                check({name, " held cout"}, 32'(ifc.cout), 32'(held_cout));
            end
            if (ifc.done === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({name, " done seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " busy at done"}, 32'(ifc.busy), 32'd0);
            check({name, " busy cycles"}, 32'(busy_n), 32'(W));
            check({name, " sum"}, 32'(ifc.sum), 32'(full[W-1:0]));
            check({name, " cout"}, 32'(ifc.cout), 32'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
            check({name, " ovf"}, 32'(ifc.ovf),
                  32'((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])));
`endif
            @(negedge clk);
            check({name, " done width"}, 32'(ifc.done), 32'd0);
        end
        held_sum  = full[W-1:0];
        held_cout = full[W];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[7];
        int    n_done;
        logic [W-1:0] cap_sum;
        logic         cap_cout;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
        vecs[3] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, sum: 8'h4B, cout: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[6] = '{a: 8'h40, b: 8'h20, cin: 1'b0, sum: 8'h60, cout: 1'b0};

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.cin   = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(ifc.busy), 32'd0);
        check("reset done", 32'(ifc.done), 32'd0);
        check("reset sum", 32'(ifc.sum), 32'd0);
        check("reset cout", 32'(ifc.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset ovf", 32'(ifc.ovf), 32'd0);
`endif
        rst_n = 1'b1;

        // Table vectors: expected sum/cout written by hand.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table sum", i), 32'(ifc.sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d table cout", i), 32'(ifc.cout), 32'(vecs[i].cout));
        end

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'h12; ifc.b = 8'h34; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF;
        @(negedge clk);
        ifc.start = 1'b0;
        n_done   = 0;
        cap_sum  = '1;
        cap_cout = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (ifc.done === 1'b1) begin
                n_done++;
                cap_sum  = ifc.sum;
                cap_cout = ifc.cout;
            end
            @(negedge clk);
        end
        check("ignore start done count", 32'(n_done), 32'd1);
        check("ignore start sum", 32'(cap_sum), 32'h46);
        check("ignore start cout", 32'(cap_cout), 32'd0);

        // Reset in the middle of RUN abandons the operation.
        ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.cin = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun reset busy", 32'(ifc.busy), 32'd0);
        check("midrun reset done", 32'(ifc.done), 32'd0);
        check("midrun reset sum", 32'(ifc.sum), 32'd0);
        check("midrun reset cout", 32'(ifc.cout), 32'd0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (ifc.done === 1'b1) n_done++;
            @(negedge clk);
        end
        check("midrun reset no done", 32'(n_done), 32'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        do_op(8'h01, 8'h01, 1'b0, "after reset");

        // Start held high: one op every WIDTH+2 cycles.
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'h21; ifc.b = 8'h43; ifc.cin = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) n_done++;
            if (ifc.busy === 1'b1 && ifc.done === 1'b1)
                check("held start busy&done", 32'd1, 32'd0);
        end
        ifc.start = 1'b0;
        check("held start done count", 32'(n_done), 32'd3);
        check("held start sum", 32'(ifc.sum), 32'h65);
        repeat (W + 3) @(negedge clk);
        held_sum  = 8'h65;
        held_cout = 1'b0;

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
